// File: rtl/design_03_pkg.sv
// design_03_pkg: shared width default and handshake type for the registered adder
package design_03_pkg;
    localparam int DEFAULT_W = 16;
    typedef struct packed {
        logic                 valid;
        logic [DEFAULT_W-1:0] data;
    } hs_t;
endpackage

// File: rtl/design_03_add_reg.sv
// design_03_add_reg: W-bit adder feeding an enable-loaded register with async active-low clear
module design_03_add_reg
    import design_03_pkg::*;
#(
    parameter int W = DEFAULT_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] q
);
    // Carry-out is dropped by the W-bit destination
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n)  q <= '0;
        else if (en) q <= a + b;
endmodule

// File: rtl/design_03.sv
// design_03: single-stage registered adder with start/valid handshake, fixed 1-cycle latency
module design_03
    import design_03_pkg::*;
#(
    parameter int W = DEFAULT_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] y,
    output logic         valid
);
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) valid <= 1'b0;
        else        valid <= start;

    design_03_add_reg #(.W(W)) u_add_reg (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (start),
        .a     (a),
        .b     (b),
        .q     (y)
    );
endmodule

// File: tb/tb_design_03.sv
// tb_design_03: directed scoreboard bench for design_03 at the default 16-bit width
module tb_design_03;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] a = '0;
    logic [15:0] b = '0;
    logic [15:0] y;
    logic        valid;
    logic [15:0] q[$];
    logic [15:0] exp_y = '0;
    int          tests = 0;
    int          fails = 0;

    design_03 #(.W(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .y     (y),
        .valid (valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive one cycle, push the expected sum on a live start, then check after the edge
    task automatic step(input string tag, input logic s, input logic [15:0] aa, input logic [15:0] bb);
        logic [15:0] sum;
        logic        exp_v;
        start = s;
        a = aa;
        b = bb;
        sum = aa + bb;
        if (s && rst_n) q.push_back(sum);
        @(posedge clk);
        #1;
        exp_v = s && rst_n;
        if (!rst_n) exp_y = '0;
        else if (exp_v) exp_y = q.pop_front();
        chk({tag, "_valid"}, {15'd0, valid}, {15'd0, exp_v});
        chk({tag, "_y"}, y, exp_y);
    endtask

    initial begin
        #1;
        chk("rst_async_valid", {15'd0, valid}, 16'd0);
        chk("rst_async_y", y, 16'd0);
        step("rst_hold0", 1'b1, 16'h1111, 16'h2222);
        step("rst_hold1", 1'b0, 16'h3333, 16'h4444);
        step("rst_hold2", 1'b1, 16'h5555, 16'h6666);
        rst_n = 1'b1;
        step("post_rst_idle0", 1'b0, 16'h0001, 16'h0001);
        step("post_rst_idle1", 1'b0, 16'h0002, 16'h0002);

        step("single", 1'b1, 16'h0123, 16'h0045);
        chk("single_sum", y, 16'h0168);
        step("single_hold", 1'b0, 16'hAAAA, 16'h5555);
        chk("single_hold_sum", y, 16'h0168);

        step("wrap", 1'b1, 16'hFFFF, 16'h0002);
        chk("wrap_sum", y, 16'h0001);
        step("wrap_ffff", 1'b1, 16'hFFFF, 16'h0001);
        chk("wrap_ffff_sum", y, 16'h0000);

        step("b2b0", 1'b1, 16'd1, 16'd2);
        chk("b2b0_sum", y, 16'd3);
        step("b2b1", 1'b1, 16'd10, 16'd20);
        chk("b2b1_sum", y, 16'd30);
        step("b2b2", 1'b1, 16'h8000, 16'h8000);
        chk("b2b2_sum", y, 16'h0000);
        step("b2b3", 1'b1, 16'h1234, 16'h4321);
        chk("b2b3_sum", y, 16'h5555);

        for (int i = 0; i < 6; i++)
            step("churn", 1'b0, 16'($urandom), 16'($urandom));
        chk("churn_sum", y, 16'h5555);

        step("midop_start", 1'b1, 16'd5, 16'd6);
        chk("midop_sum", y, 16'd11);
        rst_n = 1'b0;
        #1;
        exp_y = '0;
        chk("midop_async_valid", {15'd0, valid}, 16'd0);
        chk("midop_async_y", y, 16'd0);
        step("midop_rst_start", 1'b1, 16'd7, 16'd8);
        rst_n = 1'b1;
        step("midop_rel0", 1'b0, 16'd9, 16'd9);
        step("midop_rel1", 1'b0, 16'd3, 16'd4);
        step("midop_new", 1'b1, 16'd100, 16'd23);
        chk("midop_new_sum", y, 16'd123);
        step("final_idle", 1'b0, 16'd0, 16'd0);

        chk("queue_empty", 16'(q.size()), 16'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/design_03.md
Name: design_03

Overview:
- Single-stage registered adder with a start/valid handshake.
- On each cycle where start is sampled high, the block captures a+b (modulo 2^W) into an output register and pulses valid exactly one clock later.
- Used as a small, fixed-latency arithmetic leaf inside a datapath. No backpressure, no internal queueing.

Parameters:
- W, default 16, operand and result width in bits (legal range 1..64).

Ports:
- clk    input   1   rising-edge clock
- rst_n  input   1   reset, asynchronous, active-low
- start  input   1   request; operands a/b are valid in the same cycle
- a      input   W   operand A, unsigned
- b      input   W   operand B, unsigned
- y      output  W   registered sum, (a+b) mod 2^W
- valid  output  1   high for the cycle in which y holds a freshly computed sum

Behaviour:
- Reset: rst_n low asynchronously forces valid=0 and y=0, independent of clk.
  - Both outputs stay 0 for every clock edge while rst_n is low.
  - Release of rst_n is synchronous in effect: the first edge with rst_n high behaves as normal operation.
- Latency: fixed 1 cycle.
  - If start=1 at rising edge N, then after edge N: y = a+b sampled at edge N, and valid=1.
  - valid is observed high at edge N+1.
- valid register: next valid = start. valid never stays high without a start on the previous edge.
- y register:
  - Loads a+b only when start=1.
  - Holds its last value when start=0, so y remains stable after valid falls.
- Arithmetic: unsigned W-bit add. Carry-out is discarded and no overflow flag is produced.
  - Example for W=16: 0xFFFF+0x0001 gives y=0x0000.
- Back-to-back starts: start high on consecutive edges keeps valid high on consecutive cycles. y updates every cycle with the matching sum. No bubbles, no stalls.
- a/b while start=0 are don't-care and must not affect y or valid.
- Reset mid-operation: if rst_n asserts in the cycle after start, the pending result is dropped. valid=0 and y=0, and no valid pulse follows reset release unless a new start occurs.
- start asserted during reset is ignored.
- No X propagation: outputs are defined from reset onward.

Decomposition:
- Package design_03_pkg holds:
  - localparam DEFAULT_W = 16
  - typedef for the handshake pair, a struct {logic valid; logic [W-1:0] data}, used only for the default width.
- One natural sub-module, design_03_add_reg. It is a parameterised W-bit adder plus enable-loaded register with async active-low clear.
- The top-level holds the valid flop and instantiates design_03_add_reg.
- Optionally add embedded assertions in the top-level, guarded by a synthesis-off region:
  - start |=> valid
  - !rst_n -> !valid
  - valid -> y equals the sum captured on the previous start

Test Plan:
- Reset hold: rst_n=0 for 3 edges with start toggling -> valid=0 and y=0 on every edge; no valid after release without a start.
- Single op (W=16): a=0x0123, b=0x0045, start pulsed for 1 cycle -> next edge valid=1, y=0x0168. Following edge valid=0, y still 0x0168.
- Wrap-around: a=0xFFFF, b=0x0002, start=1 -> valid=1, y=0x0001.
- Back-to-back: start high 3 cycles with (1,2), (10,20), (0x8000,0x8000) -> valid high 3 consecutive cycles with y=3, 30, 0x0000.
- Idle operand churn: start=0 while a/b change randomly -> y unchanged and valid=0.
- Reset mid-op: start=1 with a=5, b=6, then rst_n asserted before the next edge -> valid=0 and y=0 immediately. After release, no valid pulse until the next start.
